// File: rtl/tx_packet_sequencer.sv
// tx_packet_sequencer: transmit-side scheduler that assembles one USB packet
// at a time from the PID, non-data, data and data-CRC FIFOs, hands each byte
// to the shift register over a load handshake, then requests EOP and enforces
// an inter-packet gap.
// Optional feature macro: TX_ENCRYPT_SEL_EN (adds an encrypted-payload FIFO
// selectable per packet through encrypt_sel).
module tx_packet_sequencer #(
  parameter int MAX_DATA   = 64,
  parameter int ND_BYTES   = 2,
  parameter int CRC_BYTES  = 2,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pid_empty,
  input  logic [7:0] pid_read,
  input  logic       nd_empty,
  input  logic [7:0] nd_read,
  input  logic       data_empty,
  input  logic [7:0] data_read,
  input  logic       dcrc_empty,
  input  logic [7:0] dcrc_read,
  input  logic [6:0] data_len,
  input  logic       tx_ready,
`ifdef TX_ENCRYPT_SEL_EN
  input  logic       encrypt_sel,
  input  logic       encrypt_empty,
  input  logic [7:0] encrypt_read,
  output logic       rencrypt_enable,
`endif
  output logic       pid_enable,
  output logic       nd_enable,
  output logic       data_enable,
  output logic       dcrc_enable,
  output logic [7:0] write,
  output logic       write_enable,
  output logic       eop_enable,
  output logic       busy,
  output logic       pid_error,
  output logic       underrun
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PID   = 3'd1;
  localparam logic [2:0] S_ND    = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CRC   = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_EOP   = 3'd6;
  localparam logic [2:0] S_GAP   = 3'd7;

  localparam logic [6:0] MAX_LEN  = 7'(MAX_DATA);
  localparam logic [6:0] ND_CNT   = 7'(ND_BYTES);
  localparam logic [6:0] CRC_CNT  = 7'(CRC_BYTES);
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  logic [2:0] state;
  logic [6:0] byte_cnt;
  logic [6:0] len_q;
  logic [7:0] wait_cnt;
  logic [7:0] gap_cnt;
`ifdef TX_ENCRYPT_SEL_EN
  logic       enc_q;
`endif

  logic       in_load_state;
  logic       src_empty;
  logic [7:0] src_byte;
  logic [6:0] term_cnt;
  logic [2:0] done_state;
  logic       load;
  logic       timeout_hit;
  logic       pid_ok;
  logic [6:0] len_clamped;
  logic [6:0] byte_cnt_inc;

  assign in_load_state = (state == S_ND) || (state == S_DATA) || (state == S_CRC);
  // A PID is well-formed when its upper nibble is the complement of the lower
  // nibble; class 00 is reserved and treated as malformed.
  assign pid_ok       = (pid_read[7:4] == ~pid_read[3:0]) && (pid_read[1:0] != 2'b00);
  assign len_clamped  = (data_len > MAX_LEN) ? MAX_LEN : data_len;
  assign byte_cnt_inc = byte_cnt + 7'd1;
  // tx_ready is only trusted once our own previous load pulse has retired,
  // which also lets the FIFO pop settle before its head is read again.
  assign load         = in_load_state && !src_empty && tx_ready && !write_enable;
  assign timeout_hit  = in_load_state && (wait_cnt == TO_LIMIT);

  // Select the byte source, terminal count and follow-on state for this phase.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    src_empty  = 1'b1;
    src_byte   = 8'h00;
    term_cnt   = 7'd0;
    done_state = S_DRAIN;
    case (state)
      S_ND: begin
        src_empty = nd_empty;
        src_byte  = nd_read;
        term_cnt  = ND_CNT;
      end
      S_DATA: begin
`ifdef TX_ENCRYPT_SEL_EN
        src_empty = enc_q ? encrypt_empty : data_empty;
        src_byte  = enc_q ? encrypt_read  : data_read;
`else
        src_empty = data_empty;
        src_byte  = data_read;
`endif
        term_cnt   = len_q;
        done_state = S_CRC;
      end
      S_CRC: begin
        src_empty = dcrc_empty;
        src_byte  = dcrc_read;
        term_cnt  = CRC_CNT;
      end
      default: ;
    endcase
  end

  // Packet FSM with registered pulse outputs and byte/wait/gap counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      byte_cnt     <= 7'd0;
      len_q        <= 7'd0;
      wait_cnt     <= 8'd0;
      gap_cnt      <= 8'd0;
      pid_enable   <= 1'b0;
      nd_enable    <= 1'b0;
      data_enable  <= 1'b0;
      dcrc_enable  <= 1'b0;
      write        <= 8'h00;
      write_enable <= 1'b0;
      eop_enable   <= 1'b0;
      busy         <= 1'b0;
      pid_error    <= 1'b0;
      underrun     <= 1'b0;
`ifdef TX_ENCRYPT_SEL_EN
      enc_q           <= 1'b0;
      rencrypt_enable <= 1'b0;
`endif
    end else begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples pre-edge values and simulation matches the synthesized flops.
      pid_enable   <= 1'b0;
      nd_enable    <= 1'b0;
      data_enable  <= 1'b0;
      dcrc_enable  <= 1'b0;
      write_enable <= 1'b0;
      eop_enable   <= 1'b0;
      pid_error    <= 1'b0;
      underrun     <= 1'b0;
`ifdef TX_ENCRYPT_SEL_EN
      rencrypt_enable <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          // Skip the cycle in which a PID pop is still retiring: the FIFO
          // head is stale until that pop lands.
          if (!pid_empty && !pid_enable) begin
            state <= S_PID;
            busy  <= 1'b1;
          end
        end
        S_PID: begin
          if (!pid_ok) begin
            pid_enable <= 1'b1;
            pid_error  <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else if (tx_ready) begin
            write        <= pid_read;
            write_enable <= 1'b1;
            pid_enable   <= 1'b1;
            len_q        <= len_clamped;
            byte_cnt     <= 7'd0;
            wait_cnt     <= 8'd0;
`ifdef TX_ENCRYPT_SEL_EN
            enc_q        <= encrypt_sel;
`endif
            case (pid_read[1:0])
              2'b01:   state <= S_ND;
              2'b11:   state <= (len_clamped == 7'd0) ? S_CRC : S_DATA;
              default: state <= S_DRAIN;
            endcase
          end
        end
        S_ND, S_DATA, S_CRC: begin
          // Timeout wins over a byte that shows up in the same cycle.
          if (timeout_hit) begin
            underrun <= 1'b1;
            wait_cnt <= 8'd0;
            byte_cnt <= 7'd0;
            state    <= S_DRAIN;
          end else if (load) begin
            write        <= src_byte;
            write_enable <= 1'b1;
            wait_cnt     <= 8'd0;
            case (state)
              S_ND:  nd_enable   <= 1'b1;
              S_CRC: dcrc_enable <= 1'b1;
`ifdef TX_ENCRYPT_SEL_EN
              default: begin
                if (enc_q) rencrypt_enable <= 1'b1;
                else       data_enable     <= 1'b1;
              end
`else
              default: data_enable <= 1'b1;
`endif
            endcase
            if (byte_cnt_inc == term_cnt) begin
              byte_cnt <= 7'd0;
              state    <= done_state;
            end else begin
              byte_cnt <= byte_cnt_inc;
            end
          end else if (src_empty) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DRAIN: begin
          if (tx_ready && !write_enable) state <= S_EOP;
        end
        S_EOP: begin
          eop_enable <= 1'b1;
          gap_cnt    <= 8'd0;
          state      <= S_GAP;
        end
        default: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_packet_sequencer.sv
// Testbench for tx_packet_sequencer: FWFT FIFO and shift-register models
// around the DUT, a packet-level reference model and scoreboard, directed
// scenarios plus randomized packets.
module tb_tx_packet_sequencer;

  localparam int MAX_DATA   = 64;
  localparam int ND_BYTES   = 2;
  localparam int CRC_BYTES  = 2;
  localparam int GAP_CYCLES = 16;
  localparam int TIMEOUT    = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       pid_empty, nd_empty, data_empty, dcrc_empty, tx_ready;
  logic [7:0] pid_read, nd_read, data_read, dcrc_read;
  logic [6:0] data_len;
  logic       pid_enable, nd_enable, data_enable, dcrc_enable;
  logic [7:0] write;
  logic       write_enable, eop_enable, busy, pid_error, underrun;
`ifdef TX_ENCRYPT_SEL_EN
  logic       rencrypt_enable;
`endif

  tx_packet_sequencer #(
    .MAX_DATA(MAX_DATA), .ND_BYTES(ND_BYTES), .CRC_BYTES(CRC_BYTES),
    .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .pid_empty(pid_empty), .pid_read(pid_read),
    .nd_empty(nd_empty), .nd_read(nd_read),
    .data_empty(data_empty), .data_read(data_read),
    .dcrc_empty(dcrc_empty), .dcrc_read(dcrc_read),
    .data_len(data_len), .tx_ready(tx_ready),
`ifdef TX_ENCRYPT_SEL_EN
    .encrypt_sel(1'b0), .encrypt_empty(1'b1), .encrypt_read(8'h00),
    .rencrypt_enable(rencrypt_enable),
`endif
    .pid_enable(pid_enable), .nd_enable(nd_enable),
    .data_enable(data_enable), .dcrc_enable(dcrc_enable),
    .write(write), .write_enable(write_enable), .eop_enable(eop_enable),
    .busy(busy), .pid_error(pid_error), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Bench-side FIFO contents (what the DUT sees) and model copies.
  logic [7:0] f_pid[$], f_nd[$], f_data[$], f_crc[$];
  logic [6:0] f_len[$];
  logic [7:0] m_nd[$], m_data[$], m_crc[$];
  logic [7:0] exp_w[$], act_w[$];

  int exp_pid_pops, exp_nd_pops, exp_data_pops, exp_crc_pops, exp_err, exp_under, exp_eop;
  int act_pid_pops, act_nd_pops, act_data_pops, act_crc_pops, act_err, act_under, act_eop;
  int cycle, last_we_cyc, spacing_err, width_err, shift_cnt;
  int eop_cyc, busy_fall_cyc, under_cyc;
  logic [7:0] prev_p;
  logic prev_busy;
  logic pend_pid, pend_nd, pend_data, pend_crc, pend_tx;
  int checks, errors;

  task automatic refresh();
    pid_empty  = (f_pid.size() == 0);
    pid_read   = pid_empty ? 8'h00 : f_pid[0];
    data_len   = (f_len.size() == 0) ? 7'd0 : f_len[0];
    nd_empty   = (f_nd.size() == 0);
    nd_read    = nd_empty ? 8'h00 : f_nd[0];
    data_empty = (f_data.size() == 0);
    data_read  = data_empty ? 8'h00 : f_data[0];
    dcrc_empty = (f_crc.size() == 0);
    dcrc_read  = dcrc_empty ? 8'h00 : f_crc[0];
  endtask

  // One clock: observe at the falling edge, then apply FIFO pops and the
  // shift-register response just after the rising edge that consumes them.
  task automatic step();
    logic [7:0] cur, dummy;
    @(negedge clk);
    cycle++;
    if (rst) begin
      {pend_pid, pend_nd, pend_data, pend_crc, pend_tx} = '0;
      prev_p = '0;
      prev_busy = 1'b0;
    end else begin
      pend_pid = pid_enable; pend_nd = nd_enable; pend_data = data_enable;
      pend_crc = dcrc_enable; pend_tx = write_enable;
      if (write_enable) begin
        act_w.push_back(write);
        if (cycle - last_we_cyc < 2) spacing_err++;
        last_we_cyc = cycle;
      end
      cur = {pid_enable, nd_enable, data_enable, dcrc_enable,
             write_enable, eop_enable, pid_error, underrun};
      if ((cur & prev_p) != 8'h00) width_err++;
      prev_p = cur;
      act_pid_pops += int'(pid_enable);  act_nd_pops  += int'(nd_enable);
      act_data_pops += int'(data_enable); act_crc_pops += int'(dcrc_enable);
      act_err += int'(pid_error); act_under += int'(underrun); act_eop += int'(eop_enable);
      if (eop_enable) eop_cyc = cycle;
      if (underrun) under_cyc = cycle;
      if (prev_busy && !busy) busy_fall_cyc = cycle;
      prev_busy = busy;
    end
    @(posedge clk);
    #1;
    if (pend_pid && f_pid.size() > 0) begin dummy = f_pid.pop_front(); f_len.delete(0); end
    if (pend_nd && f_nd.size() > 0) dummy = f_nd.pop_front();
    if (pend_data && f_data.size() > 0) dummy = f_data.pop_front();
    if (pend_crc && f_crc.size() > 0) dummy = f_crc.pop_front();
    if (pend_tx) begin
      tx_ready  = 1'b0;
      shift_cnt = $urandom_range(1, 4);
    end else if (shift_cnt > 0) begin
      shift_cnt--;
      if (shift_cnt == 0) tx_ready = 1'b1;
    end
    {pend_pid, pend_nd, pend_data, pend_crc, pend_tx} = '0;
    refresh();
  endtask

  // Reference model: which bytes a packet emits, from the PID rules and the
  // bytes queued ahead of it.
  task automatic model_packet(input logic [7:0] pid, input logic [6:0] len);
    int n;
    bit short_pkt;
    exp_pid_pops++;
    if ((pid[7:4] != ~pid[3:0]) || (pid[1:0] == 2'b00)) begin
      exp_err++;
      return;
    end
    exp_w.push_back(pid);
    exp_eop++;
    short_pkt = 1'b0;
    if (pid[1:0] == 2'b01) begin
      for (int i = 0; i < ND_BYTES; i++) begin
        if (m_nd.size() == 0) begin short_pkt = 1'b1; break; end
        exp_w.push_back(m_nd.pop_front()); exp_nd_pops++;
      end
    end else if (pid[1:0] == 2'b11) begin
      n = (int'(len) > MAX_DATA) ? MAX_DATA : int'(len);
      for (int i = 0; i < n; i++) begin
        if (m_data.size() == 0) begin short_pkt = 1'b1; break; end
        exp_w.push_back(m_data.pop_front()); exp_data_pops++;
      end
      if (!short_pkt) begin
        for (int i = 0; i < CRC_BYTES; i++) begin
          if (m_crc.size() == 0) begin short_pkt = 1'b1; break; end
          exp_w.push_back(m_crc.pop_front()); exp_crc_pops++;
        end
      end
    end
    if (short_pkt) exp_under++;
  endtask

  task automatic push_byte(input int kind, input logic [7:0] b);
    case (kind)
      0: begin f_nd.push_back(b);   m_nd.push_back(b);   end
      1: begin f_data.push_back(b); m_data.push_back(b); end
      default: begin f_crc.push_back(b); m_crc.push_back(b); end
    endcase
  endtask

  task automatic push_pid(input logic [7:0] pid, input logic [6:0] len);
    f_pid.push_back(pid);
    f_len.push_back(len);
    model_packet(pid, len);
  endtask

  task automatic clear_score();
    exp_w.delete(); act_w.delete();
    {exp_pid_pops, exp_nd_pops, exp_data_pops, exp_crc_pops, exp_err, exp_under, exp_eop} = '0;
    {act_pid_pops, act_nd_pops, act_data_pops, act_crc_pops, act_err, act_under, act_eop} = '0;
    spacing_err = 0; width_err = 0;
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int quiet, n;
    quiet = 0; n = 0;
    while (quiet < 3 && n < budget) begin
      step();
      n++;
      if (f_pid.size() == 0 && !busy && !pid_enable) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 3) begin
      errors++;
      $display("FAIL %s: idle_timeout got busy=%0b after %0d cycles, required idle", name, busy, n);
    end
  endtask

  task automatic score_packets(input string name);
    checks++;
    if (act_w.size() != exp_w.size()) begin
      errors++;
      $display("FAIL %s: write_count got %0d required %0d", name, act_w.size(), exp_w.size());
    end else begin
      foreach (exp_w[i]) begin
        checks++;
        if (act_w[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL %s: write[%0d] got %02h required %02h", name, i, act_w[i], exp_w[i]);
        end
      end
    end
    checks++;
    if (act_pid_pops != exp_pid_pops || act_nd_pops != exp_nd_pops ||
        act_data_pops != exp_data_pops || act_crc_pops != exp_crc_pops) begin
      errors++;
      $display("FAIL %s: pops got pid/nd/data/crc=%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d", name,
               act_pid_pops, act_nd_pops, act_data_pops, act_crc_pops,
               exp_pid_pops, exp_nd_pops, exp_data_pops, exp_crc_pops);
    end
    checks++;
    if (act_err != exp_err || act_under != exp_under || act_eop != exp_eop) begin
      errors++;
      $display("FAIL %s: events got pid_error/underrun/eop=%0d/%0d/%0d required %0d/%0d/%0d", name,
               act_err, act_under, act_eop, exp_err, exp_under, exp_eop);
    end
    checks++;
    if (spacing_err != 0 || width_err != 0) begin
      errors++;
      $display("FAIL %s: timing got spacing/width violations=%0d/%0d required 0/0", name,
               spacing_err, width_err);
    end
    checks++;
    if (f_nd.size() != m_nd.size() || f_data.size() != m_data.size() || f_crc.size() != m_crc.size()) begin
      errors++;
      $display("FAIL %s: fifo_residue got nd/data/crc=%0d/%0d/%0d required %0d/%0d/%0d", name,
               f_nd.size(), f_data.size(), f_crc.size(), m_nd.size(), m_data.size(), m_crc.size());
    end
  endtask

  task automatic flush_all();
    f_pid.delete(); f_len.delete(); f_nd.delete(); f_data.delete(); f_crc.delete();
    m_nd.delete(); m_data.delete(); m_crc.delete();
    refresh();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({pid_enable, nd_enable, data_enable, dcrc_enable, write, write_enable,
         eop_enable, busy, pid_error, underrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%0b write=%02h busy=%0b required all zero",
               write_enable, write, busy);
    end
    rst = 1'b0;
    clear_score();
    repeat (5) step();
    checks++;
    if (act_w.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got writes=%0d busy=%0b required 0/0", act_w.size(), busy);
    end
  endtask

  task automatic test_handshake();
    clear_score();
    push_pid(8'hD2, 7'd0);
    run_until_idle("handshake", 500);
    score_packets("handshake");
    checks++;
    if (busy_fall_cyc - eop_cyc < GAP_CYCLES || busy_fall_cyc - eop_cyc > GAP_CYCLES + 1) begin
      errors++;
      $display("FAIL handshake_gap: got %0d cycles from EOP to idle required %0d",
               busy_fall_cyc - eop_cyc, GAP_CYCLES);
    end
  endtask

  task automatic test_token();
    clear_score();
    push_byte(0, 8'h15); push_byte(0, 8'h8A);
    push_pid(8'hE1, 7'd0);
    run_until_idle("token", 500);
    score_packets("token");
  endtask

  task automatic test_data();
    clear_score();
    push_byte(1, 8'h11); push_byte(1, 8'h22); push_byte(1, 8'h33);
    push_byte(2, 8'hAB); push_byte(2, 8'hCD);
    push_pid(8'hC3, 7'd3);
    run_until_idle("data_len3", 500);
    score_packets("data_len3");
    clear_score();
    push_byte(2, 8'hAB); push_byte(2, 8'hCD);
    push_pid(8'hC3, 7'd0);
    run_until_idle("data_len0", 500);
    score_packets("data_len0");
  endtask

  task automatic test_bad_pid();
    clear_score();
    push_pid(8'hC4, 7'd0);
    push_pid(8'hF0, 7'd0);
    run_until_idle("bad_pid", 200);
    score_packets("bad_pid");
  endtask

  task automatic test_underrun();
    clear_score();
    push_byte(1, 8'h01); push_byte(1, 8'h02);
    push_byte(2, 8'hAB); push_byte(2, 8'hCD);
    push_pid(8'hC3, 7'd4);
    run_until_idle("underrun", 2000);
    score_packets("underrun");
    checks++;
    if (under_cyc - last_we_cyc < TIMEOUT || under_cyc - last_we_cyc > TIMEOUT + 3) begin
      errors++;
      $display("FAIL underrun_delay: got %0d cycles after last byte required about %0d",
               under_cyc - last_we_cyc, TIMEOUT);
    end
    flush_all();
  endtask

  task automatic test_reset_mid_packet();
    int n;
    clear_score();
    for (int i = 0; i < 4; i++) push_byte(1, 8'(8'h40 + i));
    push_byte(2, 8'hAB); push_byte(2, 8'hCD);
    push_pid(8'hC3, 7'd4);
    n = 0;
    while (act_w.size() < 3 && n < 500) begin step(); n++; end
    rst = 1'b1;
    #1;
    checks++;
    if ({pid_enable, nd_enable, data_enable, dcrc_enable, write, write_enable,
         eop_enable, busy, pid_error, underrun} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got we=%0b write=%02h busy=%0b required all zero",
               write_enable, write, busy);
    end
    repeat (3) step();
    checks++;
    if (act_w.size() != 3 || f_data.size() != 2 || f_crc.size() != 2 || act_eop != 0) begin
      errors++;
      $display("FAIL midreset_fifos: got writes=%0d data_left=%0d crc_left=%0d eop=%0d required 3/2/2/0",
               act_w.size(), f_data.size(), f_crc.size(), act_eop);
    end
    flush_all();
    shift_cnt = 0;
    tx_ready = 1'b1;
    rst = 1'b0;
    clear_score();
    push_pid(8'hD2, 7'd0);
    run_until_idle("after_reset", 500);
    score_packets("after_reset");
  endtask

  task automatic push_random_packet();
    logic [3:0] lo;
    logic [7:0] pid;
    logic [6:0] len;
    int kind, n;
    kind = $urandom_range(0, 3);
    len  = 7'($urandom_range(0, 100));
    lo   = 4'($urandom_range(0, 15));
    case (kind)
      0: lo[1:0] = 2'b01;
      1: lo[1:0] = 2'b11;
      2: lo[1:0] = 2'b10;
      default: ;
    endcase
    pid = {~lo, lo};
    if (kind == 3) begin
      pid = 8'($urandom_range(0, 255));
      if ((pid[7:4] == ~pid[3:0]) && (pid[1:0] != 2'b00)) pid[4] = ~pid[4];
    end
    if (kind == 0) for (int i = 0; i < ND_BYTES; i++) push_byte(0, 8'($urandom_range(0, 255)));
    if (kind == 1) begin
      n = (int'(len) > MAX_DATA) ? MAX_DATA : int'(len);
      for (int i = 0; i < n; i++) push_byte(1, 8'($urandom_range(0, 255)));
      for (int i = 0; i < CRC_BYTES; i++) push_byte(2, 8'($urandom_range(0, 255)));
    end
    push_pid(pid, len);
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      clear_score();
      push_random_packet();
      run_until_idle("random", 5000);
      score_packets("random");
    end
  endtask

  task automatic test_back_to_back();
    clear_score();
    push_byte(0, 8'h5A); push_byte(0, 8'hA5);
    for (int i = 0; i < 5; i++) push_byte(1, 8'(8'h90 + i));
    push_byte(2, 8'h12); push_byte(2, 8'h34);
    push_pid(8'h87, 7'd0);
    push_pid(8'h4B, 7'd5);
    push_pid(8'h5A, 7'd0);
    push_pid(8'hD2, 7'd0);
    run_until_idle("back_to_back", 3000);
    score_packets("back_to_back");
  endtask

  initial begin
    checks = 0; errors = 0; cycle = 0; last_we_cyc = -10; shift_cnt = 0;
    eop_cyc = 0; busy_fall_cyc = 0; under_cyc = 0; prev_p = '0; prev_busy = 1'b0;
    {pend_pid, pend_nd, pend_data, pend_crc, pend_tx} = '0;
    tx_ready = 1'b1;
    flush_all();
    test_reset();
    test_handshake();
    test_token();
    test_data();
    test_bad_pid();
    test_underrun();
    test_reset_mid_packet();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_packet_sequencer.md
Name: tx_packet_sequencer

Overview:
- Transmit-side scheduler that assembles one outgoing USB packet at a time from the PID, non-data, data and data-CRC FIFOs.
- Feeds bytes to the transmit shift register over a load handshake, then requests EOP.
- Decodes each queued PID to select the byte sources for that packet, and drops malformed PIDs.
- Sits between the four transmit-side FIFOs and transmit_shift/transmit.

Parameters:
MAX_DATA, 64, maximum data-payload bytes per packet; data_len is clamped to this value.
ND_BYTES, 2, non-data bytes following a token PID.
CRC_BYTES, 2, CRC bytes following a data payload.
GAP_CYCLES, 16, idle clocks enforced after EOP before the next packet.
TIMEOUT, 255, clocks to wait on an empty source FIFO before aborting the packet.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
pid_empty  in  1  PID FIFO empty
pid_read  in  8  PID FIFO head byte (first-word-fall-through)
nd_empty  in  1  non-data FIFO empty
nd_read  in  8  non-data FIFO head byte
data_empty  in  1  data FIFO empty
data_read  in  8  data FIFO head byte
dcrc_empty  in  1  CRC FIFO empty
dcrc_read  in  8  CRC FIFO head byte
data_len  in  7  payload length; sampled when the PID is accepted
tx_ready  in  1  shift register idle, can accept a byte
pid_enable  out  1  PID FIFO pop pulse
nd_enable  out  1  non-data FIFO pop pulse
data_enable  out  1  data FIFO pop pulse
dcrc_enable  out  1  CRC FIFO pop pulse
write  out  8  byte to shift register
write_enable  out  1  shift register load pulse
eop_enable  out  1  EOP request pulse
busy  out  1  packet in progress
pid_error  out  1  one-cycle pulse when a PID is dropped
underrun  out  1  one-cycle pulse when a packet is aborted on timeout

Behaviour:
- Reset: all outputs are registered and reset to 0; FSM enters IDLE; all counters are cleared. Reset asserted mid-packet aborts immediately, with no EOP and no pops; FIFO contents are untouched.
- States: IDLE, PID, ND, DATA, CRC, DRAIN, EOP, GAP.
- IDLE: when pid_empty=0, go to PID and set busy=1.
- PID: check pid_read[7:4] == ~pid_read[3:0].
  - If the check fails, or pid_read[1:0]=00: pop the PID (pid_enable pulse), pulse pid_error, return to IDLE with busy=0, and write nothing.
  - Otherwise, when tx_ready=1: register write=pid_read, write_enable=1, pid_enable=1 (same cycle), and latch min(data_len, MAX_DATA).
- Next state after a valid PID, by pid_read[1:0]:
  - 01 (token): ND.
  - 11 (data): DATA, or CRC if the latched length is 0.
  - 10 (handshake): DRAIN.
- Byte-load rule for ND, DATA and CRC: when the source is non-empty, tx_ready=1 and write_enable is currently 0, register write=head byte, write_enable=1, and the matching pop=1.
  - All pulses last exactly 1 cycle.
  - After any load the block holds at least 1 cycle, so the minimum is 2 clocks per byte.
  - tx_ready is ignored while write_enable=1.
- Byte counts: ND loads ND_BYTES bytes then goes to DRAIN. DATA loads the latched length then goes to CRC. CRC loads CRC_BYTES bytes then goes to DRAIN. Counters are 7 bits and never wrap; the terminal count is compared exactly.
- Timeout: an 8-bit wait counter runs while in ND/DATA/CRC with the source empty and resets on each load.
  - At TIMEOUT: pulse underrun and go to DRAIN, so the truncated packet still terminates with EOP.
  - Bytes not yet popped remain in the FIFO.
- DRAIN: wait for tx_ready=1 with write_enable=0, i.e. the last byte has been shifted out.
- EOP: eop_enable=1 for 1 cycle, then GAP.
- GAP: count GAP_CYCLES clocks, then go to IDLE with busy=0.
- Simultaneous events: a source becoming non-empty in the same cycle the timeout expires counts as a timeout.

Optional Feature:
TX_ENCRYPT_SEL_EN:
- Defined: adds ports encrypt_sel (in, 1), encrypt_empty (in, 1), encrypt_read (in, 8) and rencrypt_enable (out, 1).
  - encrypt_sel is sampled with the PID.
  - If encrypt_sel=1, DATA-state bytes come from the encrypted FIFO and are popped with rencrypt_enable; data_enable stays 0 for that packet.
- Undefined: these ports are absent and DATA always uses the data FIFO.

Test Plan:
1. PID FIFO holds D2 (ACK), tx_ready=1 -> one write of D2 with pid_enable in the same cycle, then eop_enable, then busy low after GAP_CYCLES; no other pops.
2. PID E1 (OUT); nd FIFO holds 0x15, 0x8A -> writes E1, 15, 8A, each at least 2 cycles apart, then EOP; nd_enable pulses exactly 2 times.
3. PID C3 with data_len=3; data FIFO holds 11, 22, 33; CRC FIFO holds AB, CD -> writes C3, 11, 22, 33, AB, CD, then EOP. Repeat with data_len=0 -> writes C3, AB, CD.
4. PID 0xC4 (check fails) and PID 0xF0 (class 00) -> each popped with a pid_error pulse; write_enable never asserted.
5. PID C3 with data_len=4 and only 2 data bytes present -> underrun pulse TIMEOUT cycles after the 2nd data byte, then EOP; CRC FIFO not popped.
6. rst asserted after 2 data bytes of a 4-byte packet -> all outputs 0 immediately; after release, the next PID is processed normally.
